// File: rtl/tdc_stream_sequencer.sv
// rtl/tdc_stream_sequencer.sv - serialises one acquisition of per-pixel TDC codes per SEND onto the histogram-builder write stream
// Define SEQ_DBUF_EN to add a shadow capture buffer for back-to-back acquisitions.
module tdc_stream_sequencer #(
  parameter int NP        = 10,
  parameter int PIXEL_NUM = 6,
  parameter int ACQ_NUM   = 2,
  localparam int PIX_W    = (PIXEL_NUM > 1) ? $clog2(PIXEL_NUM) : 1,
  localparam int ACQ_W    = (ACQ_NUM > 1) ? $clog2(ACQ_NUM) : 1
) (
  input  logic                    clk,
  input  logic                    res,
  input  logic                    start,
  input  logic                    tdcValid,
  input  logic [PIXEL_NUM*NP-1:0] tdcCode,
  input  logic [PIXEL_NUM-1:0]    tdcHit,
  output logic                    ready,
  output logic                    wrEn,
  output logic [NP-1:0]           data,
  output logic [PIX_W-1:0]        pixIdx,
  output logic [ACQ_W-1:0]        acqIdx,
  output logic                    frameDone,
  output logic                    overrun
);

  typedef enum logic [1:0] {IDLE, ARM, SEND, DONE} stateT;

  localparam logic [PIX_W-1:0] LAST_PIX = PIX_W'(PIXEL_NUM - 1);
  localparam logic [ACQ_W-1:0] LAST_ACQ = ACQ_W'(ACQ_NUM - 1);

  stateT                   state, stateNext;
  logic [PIX_W-1:0]        pixNext;
  logic [ACQ_W-1:0]        acqNext;
  logic                    readyNext, wrEnNext, frameDoneNext, overrunNext, accept;
  logic [NP-1:0]           dataNext;
  logic [PIXEL_NUM*NP-1:0] bufCode, bufCodeNext;
  logic [PIXEL_NUM-1:0]    bufHit, bufHitNext;
`ifdef SEQ_DBUF_EN
  localparam int CNT_W = $clog2(ACQ_NUM + 1);
  logic [PIXEL_NUM*NP-1:0] shdCode, shdCodeNext;
  logic [PIXEL_NUM-1:0]    shdHit, shdHitNext;
  logic                    shdFull, shdFullNext;
  logic [CNT_W-1:0]        capCnt, capCntNext;
`endif

  // Unhit pixels still emit a zero word so the builder keeps positional alignment.
  function automatic logic [NP-1:0] pixWord(input logic [PIXEL_NUM*NP-1:0] code,
                                            input logic [PIXEL_NUM-1:0] hit,
                                            input logic [PIX_W-1:0] idx);
    return hit[idx] ? code[idx*NP +: NP] : '0;
  endfunction

  always_comb begin
    stateNext     = state;
    pixNext       = pixIdx;
    acqNext       = acqIdx;
    wrEnNext      = 1'b0;
    dataNext      = '0;
    frameDoneNext = 1'b0;
    bufCodeNext   = bufCode;
    bufHitNext    = bufHit;
    accept        = tdcValid && ready;
    overrunNext   = overrun || (tdcValid && !ready);
`ifdef SEQ_DBUF_EN
    shdCodeNext = shdCode;
    shdHitNext  = shdHit;
    shdFullNext = shdFull;
    capCntNext  = capCnt;
`endif
    case (state)
      IDLE: begin
        if (start) begin
          stateNext   = ARM;
          acqNext     = '0;
          pixNext     = '0;
          overrunNext = tdcValid;
`ifdef SEQ_DBUF_EN
          capCntNext  = '0;
`endif
        end
      end
      ARM: begin
        if (accept) begin
          stateNext   = SEND;
          bufCodeNext = tdcCode;
          bufHitNext  = tdcHit;
          pixNext     = '0;
          wrEnNext    = 1'b1;
          dataNext    = pixWord(tdcCode, tdcHit, '0);
`ifdef SEQ_DBUF_EN
          capCntNext  = capCnt + 1'b1;
`endif
        end
      end
      SEND: begin
        if (pixIdx != LAST_PIX) begin
          pixNext  = pixIdx + 1'b1;
          wrEnNext = 1'b1;
          dataNext = pixWord(bufCode, bufHit, pixNext);
`ifdef SEQ_DBUF_EN
          if (accept) begin
            shdCodeNext = tdcCode;
            shdHitNext  = tdcHit;
            shdFullNext = 1'b1;
            capCntNext  = capCnt + 1'b1;
          end
`endif
        end else begin
          pixNext = '0;
          if (acqIdx == LAST_ACQ) begin
            stateNext     = DONE;
            frameDoneNext = 1'b1;
          end else begin
            acqNext   = acqIdx + 1'b1;
            stateNext = ARM;
`ifdef SEQ_DBUF_EN
            // A pending acquisition (shadow or arriving now) follows with no ARM gap.
            if (shdFull) begin
              stateNext   = SEND;
              bufCodeNext = shdCode;
              bufHitNext  = shdHit;
              shdFullNext = 1'b0;
              wrEnNext    = 1'b1;
              dataNext    = pixWord(shdCode, shdHit, '0);
            end else if (accept) begin
              stateNext   = SEND;
              bufCodeNext = tdcCode;
              bufHitNext  = tdcHit;
              capCntNext  = capCnt + 1'b1;
              wrEnNext    = 1'b1;
              dataNext    = pixWord(tdcCode, tdcHit, '0);
            end
`endif
          end
        end
      end
      DONE:    stateNext = IDLE;
      default: stateNext = IDLE;
    endcase
    readyNext = (stateNext == ARM);
`ifdef SEQ_DBUF_EN
    if (stateNext == SEND && !shdFullNext && capCntNext < CNT_W'(ACQ_NUM)) readyNext = 1'b1;
`endif
  end

  always_ff @(posedge clk) begin
    if (res) begin
      state     <= IDLE;
      ready     <= 1'b0;
      wrEn      <= 1'b0;
      data      <= '0;
      pixIdx    <= '0;
      acqIdx    <= '0;
      frameDone <= 1'b0;
      overrun   <= 1'b0;
      bufCode   <= '0;
      bufHit    <= '0;
`ifdef SEQ_DBUF_EN
      shdCode   <= '0;
      shdHit    <= '0;
      shdFull   <= 1'b0;
      capCnt    <= '0;
`endif
    end else begin
      state     <= stateNext;
      ready     <= readyNext;
      wrEn      <= wrEnNext;
      data      <= dataNext;
      pixIdx    <= pixNext;
      acqIdx    <= acqNext;
      frameDone <= frameDoneNext;
      overrun   <= overrunNext;
      bufCode   <= bufCodeNext;
      bufHit    <= bufHitNext;
`ifdef SEQ_DBUF_EN
      shdCode   <= shdCodeNext;
      shdHit    <= shdHitNext;
      shdFull   <= shdFullNext;
      capCnt    <= capCntNext;
`endif
    end
  end

endmodule

// File: tb/tb_tdc_stream_sequencer.sv
// tb/tb_tdc_stream_sequencer.sv - scoreboard bench for tdc_stream_sequencer (NP=10, PIXEL_NUM=3, ACQ_NUM=2)
module tb_tdc_stream_sequencer;

  typedef struct packed {
    logic [0:0] acq;
    logic [1:0] pix;
    logic [9:0] data;
  } wordT;

  logic        clk = 1'b0;
  logic        res = 1'b1;
  logic        start = 1'b0;
  logic        tdcValid = 1'b0;
  logic [29:0] tdcCode = '0;
  logic [2:0]  tdcHit = '0;
  logic        ready, wrEn, frameDone, overrun;
  logic [9:0]  data;
  logic [1:0]  pixIdx;
  logic [0:0]  acqIdx;

  int   nCompared = 0;
  int   nMismatched = 0;
  int   cyc = 0;
  int   lastWrCyc = 0;
  int   wrCount = 0;
  int   curRun = 0;
  int   fdCount = 0;
  bit   prevWr = 1'b0;
  wordT expQ[$];

  tdc_stream_sequencer #(.NP(10), .PIXEL_NUM(3), .ACQ_NUM(2)) dut (
    .clk(clk), .res(res), .start(start), .tdcValid(tdcValid), .tdcCode(tdcCode),
    .tdcHit(tdcHit), .ready(ready), .wrEn(wrEn), .data(data), .pixIdx(pixIdx),
    .acqIdx(acqIdx), .frameDone(frameDone), .overrun(overrun)
  );

  initial forever #5 clk = ~clk;
  initial forever begin
    @(posedge clk);
    cyc++;
  end

  // Scoreboard consumer: every write strobe pops one expected word.
  initial forever begin
    @(negedge clk);
    if (wrEn) begin
      wordT exp;
      curRun    = prevWr ? curRun + 1 : 1;
      lastWrCyc = cyc;
      wrCount++;
      nCompared++;
      if (expQ.size() == 0) begin
        nMismatched++;
        $display("FAIL unexpected_write: got acq=%0d pix=%0d data=%0d, required no write", acqIdx, pixIdx, data);
      end else begin
        exp = expQ.pop_front();
        if ({acqIdx, pixIdx, data} !== exp) begin
          nMismatched++;
          $display("FAIL write_word: got acq=%0d pix=%0d data=%0d, required acq=%0d pix=%0d data=%0d",
                   acqIdx, pixIdx, data, exp.acq, exp.pix, exp.data);
        end
      end
    end
    prevWr = wrEn;
    if (frameDone) fdCount++;
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic pulseStart();
    @(posedge clk); #1 start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
  endtask

  task automatic sendAcq(input logic [29:0] code, input logic [2:0] hit, input int acq);
    bit ok = 1'b0;
    for (int i = 0; i < 50 && !ok; i++) begin
      @(negedge clk);
      if (ready) ok = 1'b1;
    end
    nCompared++;
    if (!ok) begin
      nMismatched++;
      $display("FAIL ready_timeout: ready=0 after 50 cycles, required 1");
      return;
    end
    tdcCode  = code;
    tdcHit   = hit;
    tdcValid = 1'b1;
    for (int p = 0; p < 3; p++)
      expQ.push_back('{acq: 1'(acq), pix: 2'(p), data: hit[p] ? code[p*10 +: 10] : 10'd0});
    @(posedge clk); #1 tdcValid = 1'b0;
  endtask

  task automatic waitDone(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 100 && !ok; i++) begin
      @(negedge clk);
      if (frameDone) ok = 1'b1;
    end
  endtask

  task automatic test_reset();
    res = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    nCompared++;
    if ({ready, wrEn, frameDone, overrun, data, pixIdx, acqIdx} !== 17'd0) begin
      nMismatched++;
      $display("FAIL reset_outputs: got %b, required all zero", {ready, wrEn, frameDone, overrun, data, pixIdx, acqIdx});
    end
    @(posedge clk); #1 res = 1'b0;
    tdcValid = 1'b1;
    @(posedge clk); #1 tdcValid = 1'b0;
    @(negedge clk);
    nCompared++;
    if (overrun !== 1'b1 || wrEn !== 1'b0) begin
      nMismatched++;
      $display("FAIL idle_overrun: got overrun=%b wrEn=%b, required overrun=1 wrEn=0", overrun, wrEn);
    end
  endtask

  task automatic test_basic_frame();
    bit ok;
    int wr0;
    pulseStart();
    @(negedge clk);
    nCompared++;
    if (ready !== 1'b1 || overrun !== 1'b0) begin
      nMismatched++;
      $display("FAIL start_arm: got ready=%b overrun=%b, required ready=1 overrun=0", ready, overrun);
    end
    wr0 = wrCount;
    sendAcq({10'd1022, 10'd511, 10'd108}, 3'b111, 0);
    @(negedge clk);
    nCompared++;
    if (wrEn !== 1'b1 || pixIdx !== 2'd0) begin
      nMismatched++;
      $display("FAIL first_word_latency: got wrEn=%b pixIdx=%0d, required wrEn=1 pixIdx=0", wrEn, pixIdx);
    end
    sendAcq({10'd50, 10'd500, 10'd300}, 3'b111, 1);
    waitDone(ok);
    nCompared++;
    if (!ok || cyc !== lastWrCyc + 1) begin
      nMismatched++;
      $display("FAIL frame_done_timing: got found=%0d cycle=%0d, required cycle=%0d", ok, cyc, lastWrCyc + 1);
    end
    @(negedge clk);
    nCompared++;
    if (ready !== 1'b0 || frameDone !== 1'b0 || wrCount - wr0 !== 6 || expQ.size() !== 0) begin
      nMismatched++;
      $display("FAIL frame_end: got ready=%b frameDone=%b words=%0d pending=%0d, required 0 0 6 0",
               ready, frameDone, wrCount - wr0, expQ.size());
    end
  endtask

  task automatic test_missing_hit();
    bit ok;
    int wr0 = wrCount;
    pulseStart();
    sendAcq({10'd1023, 10'd700, 10'd90}, 3'b101, 0);
    sendAcq({10'd3, 10'd2, 10'd1}, 3'b010, 1);
    waitDone(ok);
    nCompared++;
    if (!ok || wrCount - wr0 !== 6 || expQ.size() !== 0) begin
      nMismatched++;
      $display("FAIL missing_hit_count: got done=%0d words=%0d pending=%0d, required 1 6 0", ok, wrCount - wr0, expQ.size());
    end
  endtask

  task automatic test_overrun();
    bit ok;
    bit expOv;
`ifdef SEQ_DBUF_EN
    expOv = 1'b0;
`else
    expOv = 1'b1;
`endif
    pulseStart();
    sendAcq({10'd30, 10'd20, 10'd10}, 3'b111, 0);
    @(posedge clk); #1;
    tdcCode  = {10'd777, 10'd666, 10'd555};
    tdcHit   = 3'b111;
    tdcValid = 1'b1;
`ifdef SEQ_DBUF_EN
    expQ.push_back('{acq: 1'b1, pix: 2'd0, data: 10'd555});
    expQ.push_back('{acq: 1'b1, pix: 2'd1, data: 10'd666});
    expQ.push_back('{acq: 1'b1, pix: 2'd2, data: 10'd777});
`endif
    @(posedge clk); #1 tdcValid = 1'b0;
    @(negedge clk);
    nCompared++;
    if (overrun !== expOv) begin
      nMismatched++;
      $display("FAIL send_overrun: got overrun=%b, required %b", overrun, expOv);
    end
`ifndef SEQ_DBUF_EN
    sendAcq({10'd60, 10'd50, 10'd40}, 3'b111, 1);
`endif
    waitDone(ok);
    @(posedge clk); #1 tdcValid = 1'b1;
    @(posedge clk); #1 tdcValid = 1'b0;
    @(negedge clk);
    nCompared++;
    if (!ok || overrun !== 1'b1) begin
      nMismatched++;
      $display("FAIL overrun_sticky: got done=%0d overrun=%b, required 1 1", ok, overrun);
    end
    pulseStart();
    @(negedge clk);
    nCompared++;
    if (overrun !== 1'b0) begin
      nMismatched++;
      $display("FAIL overrun_clear: got overrun=%b, required 0", overrun);
    end
    sendAcq({10'd0, 10'd0, 10'd0}, 3'b000, 0);
    sendAcq({10'd9, 10'd8, 10'd7}, 3'b111, 1);
    waitDone(ok);
  endtask

  task automatic test_back_to_back();
    bit ok;
    int expRun;
`ifdef SEQ_DBUF_EN
    expRun = 6;
`else
    expRun = 3;
`endif
    pulseStart();
    sendAcq({10'd13, 10'd12, 10'd11}, 3'b111, 0);
    sendAcq({10'd16, 10'd15, 10'd14}, 3'b111, 1);
    waitDone(ok);
    nCompared++;
    if (!ok || curRun !== expRun || overrun !== 1'b0) begin
      nMismatched++;
      $display("FAIL back_to_back: got done=%0d run=%0d overrun=%b, required 1 %0d 0", ok, curRun, overrun, expRun);
    end
  endtask

  task automatic test_reset_mid_frame();
    bit ok = 1'b0;
    int fd0;
    pulseStart();
    sendAcq({10'd103, 10'd102, 10'd101}, 3'b111, 0);
    for (int i = 0; i < 20 && !ok; i++) begin
      @(negedge clk);
      if (wrEn && pixIdx == 2'd1) ok = 1'b1;
    end
    res = 1'b1;
    fd0 = fdCount;
    @(posedge clk); #1;
    expQ.delete();
    res = 1'b0;
    @(negedge clk);
    nCompared++;
    if (!ok || wrEn !== 1'b0) begin
      nMismatched++;
      $display("FAIL reset_mid_wren: got found=%0d wrEn=%b, required 1 0", ok, wrEn);
    end
    repeat (8) @(negedge clk);
    nCompared++;
    if (fdCount !== fd0 || ready !== 1'b0) begin
      nMismatched++;
      $display("FAIL reset_mid_nodone: got frameDones=%0d ready=%b, required 0 0", fdCount - fd0, ready);
    end
    pulseStart();
    sendAcq({10'd203, 10'd202, 10'd201}, 3'b011, 0);
    @(negedge clk);
    nCompared++;
    if (wrEn !== 1'b1 || acqIdx !== 1'b0 || pixIdx !== 2'd0) begin
      nMismatched++;
      $display("FAIL fresh_frame_idx: got wrEn=%b acq=%0d pix=%0d, required 1 0 0", wrEn, acqIdx, pixIdx);
    end
    sendAcq({10'd206, 10'd205, 10'd204}, 3'b110, 1);
    waitDone(ok);
    nCompared++;
    if (!ok || expQ.size() !== 0) begin
      nMismatched++;
      $display("FAIL fresh_frame_done: got done=%0d pending=%0d, required 1 0", ok, expQ.size());
    end
  endtask

  initial begin
    test_reset();
    test_basic_frame();
    test_missing_hit();
    test_overrun();
    test_back_to_back();
    test_reset_mid_frame();
    repeat (3) @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
    $finish;
  end

endmodule

// File: doc/tdc_stream_sequencer.md
# tdc_stream_sequencer

Producer side of the histogram-builder write interface. Captures one acquisition's worth of per-pixel TDC codes in parallel and serialises them, one word per clock, in fixed pixel order onto `wrEn`/`data`, the stream `hisBuilderFSM` consumes. It repeats this for `ACQ_NUM` acquisitions per frame, then flags frame completion. It sits between the pixel TDC array and the histogram builder.

## Interface
- `NP`, default 10 (matches `Np` in parametersSiFH.vh): TDC code width.
- `PIXEL_NUM`, default 6: pixels per acquisition.
- `ACQ_NUM`, default 2: acquisitions per frame.
- Local parameters: `PIX_W = max(1, $clog2(PIXEL_NUM))` and `ACQ_W = max(1, $clog2(ACQ_NUM))`.
- Clock and reset:
  - `clk` in 1: single clock; all logic is on its rising edge.
  - `res` in 1: synchronous, active-high reset.
- Ports:
  - `start` in 1: one-cycle pulse that arms a new frame. Honoured only in IDLE.
  - `tdcValid` in 1: pulse meaning `tdcCode`/`tdcHit` hold one complete acquisition.
  - `tdcCode` in PIXEL_NUM*NP: flat codes; pixel p is at `[p*NP +: NP]`.
  - `tdcHit` in PIXEL_NUM: per-pixel hit flag.
  - `ready` out 1: the sequencer accepts `tdcValid` this cycle.
  - `wrEn` out 1: write strobe to the histogram builder.
  - `data` out NP: code being written.
  - `pixIdx` out PIX_W: pixel index of the current `data`.
  - `acqIdx` out ACQ_W: acquisition index of the current `data`.
  - `frameDone` out 1: one-cycle pulse after the last word of the frame.
  - `overrun` out 1: sticky; set when `tdcValid` arrives while `ready` is 0.

## Operation
- States:
  - IDLE: `ready`=0. `start` moves to ARM and clears `overrun` and the acquisition counter.
  - ARM: `ready`=1. An accepted `tdcValid` latches codes and hits into the capture buffer, then moves to SEND.
  - SEND: emits PIXEL_NUM words in order, pixel 0 first, one per cycle, with `wrEn`=1 on every cycle.
    - After pixel PIXEL_NUM-1, if `acqIdx` is ACQ_NUM-1, go to DONE.
    - Otherwise increment `acqIdx` and go to ARM. With SEQ_DBUF_EN and a filled shadow buffer, go straight to the next SEND.
  - DONE: `frameDone`=1 for one cycle, then IDLE.
- Word content: pixel with `tdcHit`=1 sends its code. Pixel with `tdcHit`=0 still sends a word with `data`=0 and `wrEn`=1, so the builder's positional pixel/acquisition alignment is preserved.
- No word is skipped. The total per frame is exactly PIXEL_NUM*ACQ_NUM `wrEn` cycles.
- `tdcValid` with `ready`=0 (IDLE, SEND without a free buffer, DONE): data is dropped and `overrun` is set. `overrun` holds until the next accepted `start` or `res`.
- `start` outside IDLE is ignored and does not abort the frame.
- `tdcValid` and `start` in the same IDLE cycle: only `start` acts; `tdcValid` counts as overrun.
- Counters: `pixIdx` wraps PIXEL_NUM-1 to 0. `acqIdx` advances only on an acquisition boundary. Non-power-of-two sizes must not emit out-of-range indices.

## Timing
- Reset values (next edge after `res`=1): state IDLE; `ready`, `wrEn`, `frameDone`, `overrun` = 0; `data`, `pixIdx`, `acqIdx` = 0; buffers marked empty.
- `res` mid-SEND: `wrEn` is 0 from the next cycle and no partial frame resumes.
- `start` at edge t: `ready`=1 from cycle t+1.
- `tdcValid` accepted at edge t: first `wrEn` (pixel 0) in cycle t+1; pixel p appears in cycle t+1+p.
- All outputs are registered. `data`, `pixIdx` and `acqIdx` are stable for the whole `wrEn` cycle.
- Last word in cycle u: `frameDone` in cycle u+1; IDLE (`ready`=0) from u+2.
- Throughput without SEQ_DBUF_EN: at least PIXEL_NUM+1 cycles per acquisition, because ARM costs one cycle.
- Throughput with SEQ_DBUF_EN: PIXEL_NUM cycles per acquisition, back to back.

## Configuration
- `SEQ_DBUF_EN` defined:
  - Adds a shadow capture buffer. `ready`=1 during SEND while the shadow is empty and more acquisitions remain.
  - A `tdcValid` captured during SEND is emitted starting the cycle after the current pixel PIXEL_NUM-1, with no gap and no ARM cycle.
  - `ready`=0 once ACQ_NUM acquisitions have been captured in the frame.
- `SEQ_DBUF_EN` undefined:
  - Single buffer; `ready` is 1 only in ARM.
  - Any `tdcValid` during SEND sets `overrun`.

## Test plan
All scenarios use NP=10, PIXEL_NUM=3, ACQ_NUM=2.
- Reset: hold `res` 2 cycles -> all outputs 0, state IDLE. Pulse `tdcValid` -> `overrun`=1, `wrEn` stays 0.
- Basic frame: `start`; `tdcValid` codes {108,511,1022} with hits 3'b111; `tdcValid` codes {300,500,50} with hits 3'b111.
  - Expect `wrEn` words 108, 511, 1022, 300, 500, 50 with (`acqIdx`,`pixIdx`) = (0,0)..(1,2).
  - Expect `frameDone` one cycle after 50.
- Missing hit: hits 3'b101 with codes {90,700,1023} -> words 90, 0, 1023, and `wrEn` is 1 for all three.
- Overrun:
  - Without the macro, `tdcValid` in the 2nd SEND cycle -> `overrun`=1 and the 3 words are unchanged.
  - `start` in the next frame clears it.
- Back-to-back with SEQ_DBUF_EN: second `tdcValid` during the first SEND -> 6 contiguous `wrEn` cycles with no gap and `overrun`=0.
- Reset mid-frame: `res` after the 2nd word -> `wrEn`=0 the next cycle, no `frameDone`. A fresh frame then starts with `acqIdx`=0, `pixIdx`=0.
